// File: rtl/keycode_event_decoder_pkg.sv
// rtl/keycode_event_decoder_pkg.sv - key codes, action indices and event types for the keycode decoder
package keycode_event_decoder_pkg;

   localparam int NUM_ACTIONS = 4;

   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_FIRE  = 8'h2C;
   localparam logic [7:0] KEY_START = 8'h28;

   localparam int ACT_LEFT  = 0;
   localparam int ACT_RIGHT = 1;
   localparam int ACT_FIRE  = 2;
   localparam int ACT_START = 3;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'b00,
      EV_RELEASE = 2'b01,
      EV_REPEAT  = 2'b10
   } ev_type_t;

   typedef struct packed {
      ev_type_t   ev_type;
      logic [1:0] action;
   } key_event_t;

   // An action is active when either packed HID byte carries its code; 8'h00 never matches.
   function automatic logic [NUM_ACTIONS-1:0] decode_actions(input logic [15:0] kc);
      logic [NUM_ACTIONS-1:0] act;
      logic [7:0]             code;
      act = '0;
      for (int b = 0; b < 2; b++) begin
         code = kc[8*b +: 8];
         act[ACT_LEFT]  = act[ACT_LEFT]  | (code == KEY_LEFT);
         act[ACT_RIGHT] = act[ACT_RIGHT] | (code == KEY_RIGHT);
         act[ACT_FIRE]  = act[ACT_FIRE]  | (code == KEY_FIRE);
         act[ACT_START] = act[ACT_START] | (code == KEY_START);
      end
      return act;
   endfunction

endpackage

// File: rtl/keycode_event_decoder_if.sv
// rtl/keycode_event_decoder_if.sv - valid/ready key event stream between decoder and game logic
interface keycode_event_decoder_if;

   logic       EvValid;
   logic       EvReady;
   logic [1:0] EvType;
   logic [1:0] EvAction;

   modport master (
      output EvValid,
      output EvType,
      output EvAction,
      input  EvReady
   );

   modport slave (
      input  EvValid,
      input  EvType,
      input  EvAction,
      output EvReady
   );

endinterface

// File: rtl/keycode_event_decoder_fifo.sv
// rtl/keycode_event_decoder_fifo.sv - show-ahead synchronous FIFO of key events
module key_event_fifo
   import keycode_event_decoder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       Clk_i,
   input  logic       Reset_i,
   input  logic       push_i,
   input  key_event_t push_data_i,
   input  logic       pop_i,
   output key_event_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   key_event_t      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   // Head is forced to zero while empty so the consumer sees a clean bus after reset.
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer and occupancy update; push+pop together leaves the count unchanged, even when full.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
         count_d = count_q + 1'b1;
      end else if (!push_i && pop_i) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer/count state register.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; when full with a pop the tail slot is the head slot being read out this cycle.
   always_ff @(posedge Clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/keycode_event_decoder.sv
// rtl/keycode_event_decoder.sv - debounce, decode and queue keycode words as game action events
module keycode_event_decoder
   import keycode_event_decoder_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 4,
   parameter int FIRE_REPEAT   = 8
) (
   input  logic                   Clk_i,
   input  logic                   Reset_i,
   input  logic [15:0]            keycode_i,
   input  logic                   FrameTick_i,
   output logic [NUM_ACTIONS-1:0] Held_o,
   output logic                   Dropped_o,
   keycode_event_decoder_if.master ev
);

   localparam int SCW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int RCW = (FIRE_REPEAT > 1)   ? $clog2(FIRE_REPEAT)   : 1;
   localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_CYCLES - 1);
   localparam logic [RCW-1:0] REPEAT_MAX = RCW'(FIRE_REPEAT - 1);

   logic [15:0]            kc_q;
   logic [SCW-1:0]         cnt_q,       cnt_d;
   logic [NUM_ACTIONS-1:0] held_q,      held_d;
   logic [NUM_ACTIONS-1:0] rise,        fall;

   logic [NUM_ACTIONS-1:0] pend_press_q, pend_press_d;
   logic [NUM_ACTIONS-1:0] pend_rel_q,   pend_rel_d;
   logic                   pend_rep_q,   pend_rep_d;
   logic [RCW-1:0]         rcnt_q,       rcnt_d;
   logic                   dropped_q,    dropped_d;

   logic [NUM_ACTIONS-1:0] clr_press, clr_rel;
   logic                   clr_rep;
   logic [NUM_ACTIONS-1:0] press_kept, rel_kept;
   logic                   rep_kept;
   logic                   rep_drop;
   logic [1:0]             press_idx, rel_idx;

   logic                   fifo_full, fifo_empty;
   logic                   push, pop, can_push;
   key_event_t             push_ev, head_ev;

   assign Held_o    = held_q;
   assign Dropped_o = dropped_q;

   // Debounce: the word must match the previous sample STABLE_CYCLES edges in a row before decode updates.
   always_comb begin
      cnt_d  = '0;
      held_d = held_q;
      if (keycode_i == kc_q) begin
         cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 1'b1;
         if (cnt_q == STABLE_MAX) begin
            held_d = decode_actions(kc_q);
         end
      end
      rise = held_d & ~held_q;
      fall = held_q & ~held_d;
   end

   // Lowest-index pending press and release, used by the serializer.
   always_comb begin
      press_idx = '0;
      rel_idx   = '0;
      for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
         if (pend_press_q[i]) begin
            press_idx = 2'(i);
         end
         if (pend_rel_q[i]) begin
            rel_idx = 2'(i);
         end
      end
   end

   // Serializer: one pending event per edge, presses before releases before the fire repeat.
   always_comb begin
      pop       = ev.EvValid && ev.EvReady;
      can_push  = !fifo_full || pop;
      push      = 1'b0;
      push_ev   = '0;
      clr_press = '0;
      clr_rel   = '0;
      clr_rep   = 1'b0;
      if (can_push) begin
         if (|pend_press_q) begin
            push               = 1'b1;
            push_ev.ev_type    = EV_PRESS;
            push_ev.action     = press_idx;
            clr_press[press_idx] = 1'b1;
         end else if (|pend_rel_q) begin
            push               = 1'b1;
            push_ev.ev_type    = EV_RELEASE;
            push_ev.action     = rel_idx;
            clr_rel[rel_idx]   = 1'b1;
         end else if (pend_rep_q) begin
            push               = 1'b1;
            push_ev.ev_type    = EV_REPEAT;
            push_ev.action     = 2'(ACT_FIRE);
            clr_rep            = 1'b1;
         end
      end
   end

   // Pending edges and fire auto-repeat; a bit being pushed this edge does not count as already pending.
   always_comb begin
      press_kept   = pend_press_q & ~clr_press;
      rel_kept     = pend_rel_q   & ~clr_rel;
      rep_kept     = pend_rep_q   & ~clr_rep;
      pend_press_d = press_kept | rise;
      pend_rel_d   = rel_kept   | fall;
      pend_rep_d   = rep_kept;
      rcnt_d       = rcnt_q;
      rep_drop     = 1'b0;
      if (fall[ACT_FIRE]) begin
         rcnt_d     = '0;
         pend_rep_d = 1'b0;
      end else if (rise[ACT_FIRE]) begin
         rcnt_d = '0;
      end else if (FrameTick_i && held_q[ACT_FIRE]) begin
         if (rcnt_q == REPEAT_MAX) begin
            rcnt_d     = '0;
            pend_rep_d = 1'b1;
            rep_drop   = rep_kept;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
      dropped_d = dropped_q | (|(press_kept & rise)) | (|(rel_kept & fall)) | rep_drop;
   end

   // Decoder state register.
   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         kc_q         <= '0;
         cnt_q        <= '0;
         held_q       <= '0;
         pend_press_q <= '0;
         pend_rel_q   <= '0;
         pend_rep_q   <= 1'b0;
         rcnt_q       <= '0;
         dropped_q    <= 1'b0;
      end else begin
         kc_q         <= keycode_i;
         cnt_q        <= cnt_d;
         held_q       <= held_d;
         pend_press_q <= pend_press_d;
         pend_rel_q   <= pend_rel_d;
         pend_rep_q   <= pend_rep_d;
         rcnt_q       <= rcnt_d;
         dropped_q    <= dropped_d;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk_i       (Clk_i),
      .Reset_i     (Reset_i),
      .push_i      (push),
      .push_data_i (push_ev),
      .pop_i       (pop),
      .head_o      (head_ev),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign ev.EvValid  = !fifo_empty;
   assign ev.EvType   = head_ev.ev_type;
   assign ev.EvAction = head_ev.action;

endmodule

// File: tb/tb_keycode_event_decoder.sv
// tb/tb_keycode_event_decoder.sv - scoreboard bench for keycode_event_decoder
module tb_keycode_event_decoder;

   localparam int SC = 4;
   localparam int FD = 4;
   localparam int FR = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] kc  = '0;
   logic        tick = 1'b0;
   logic        rdy  = 1'b0;
   logic [3:0]  held;
   logic        dropped;

   int n_vec = 0;
   int n_err = 0;

   keycode_event_decoder_if ev_if ();
   assign ev_if.EvReady = rdy;

   always #5 clk = ~clk;

   keycode_event_decoder #(
      .STABLE_CYCLES (SC),
      .FIFO_DEPTH    (FD),
      .FIRE_REPEAT   (FR)
   ) dut (
      .Clk_i       (clk),
      .Reset_i     (rst),
      .keycode_i   (kc),
      .FrameTick_i (tick),
      .Held_o      (held),
      .Dropped_o   (dropped),
      .ev          (ev_if.master)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_prev;
   int          m_run;
   logic [3:0]  m_held, m_nh;
   bit          m_press [4];
   bit          m_rel   [4];
   bit          m_rep;
   int          m_rcnt;
   int          m_occ;
   bit          m_drop;
   bit          m_pop, m_can, m_pushed;
   logic [3:0]  exp_q [$];

   function automatic logic [3:0] ref_decode(input logic [15:0] w);
      logic [7:0] codes [4];
      logic [3:0] r;
      codes[0] = 8'h04; codes[1] = 8'h07; codes[2] = 8'h2C; codes[3] = 8'h28;
      r = '0;
      for (int a = 0; a < 4; a++)
         if (w[7:0] == codes[a] || w[15:8] == codes[a]) r[a] = 1'b1;
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_prev = '0; m_run = 0; m_held = '0; m_rep = 0; m_rcnt = 0; m_occ = 0; m_drop = 0;
            for (int a = 0; a < 4; a++) begin m_press[a] = 0; m_rel[a] = 0; end
            exp_q.delete();
         end else begin
            m_pop    = (m_occ > 0) && rdy;
            m_can    = (m_occ < FD) || m_pop;
            m_pushed = 0;
            if (m_can) begin
               for (int a = 0; a < 4; a++)
                  if (!m_pushed && m_press[a]) begin
                     exp_q.push_back({2'b00, 2'(a)}); m_press[a] = 0; m_pushed = 1;
                  end
               for (int a = 0; a < 4; a++)
                  if (!m_pushed && m_rel[a]) begin
                     exp_q.push_back({2'b01, 2'(a)}); m_rel[a] = 0; m_pushed = 1;
                  end
               if (!m_pushed && m_rep) begin
                  exp_q.push_back(4'b1010); m_rep = 0; m_pushed = 1;
               end
            end
            if (kc == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else              m_run = 0;
            m_prev = kc;
            m_nh = (m_run >= SC) ? ref_decode(kc) : m_held;
            for (int a = 0; a < 4; a++) begin
               if (m_nh[a] && !m_held[a]) begin
                  if (m_press[a]) m_drop = 1;
                  m_press[a] = 1;
               end
               if (!m_nh[a] && m_held[a]) begin
                  if (m_rel[a]) m_drop = 1;
                  m_rel[a] = 1;
               end
            end
            if (m_held[2] && !m_nh[2]) begin
               m_rcnt = 0; m_rep = 0;
            end else if (!m_held[2] && m_nh[2]) begin
               m_rcnt = 0;
            end else if (tick && m_held[2]) begin
               if (m_rcnt == FR - 1) begin
                  if (m_rep) m_drop = 1;
                  m_rep = 1; m_rcnt = 0;
               end else begin
                  m_rcnt++;
               end
            end
            m_occ  = m_occ + (m_pushed ? 1 : 0) - (m_pop ? 1 : 0);
            m_held = m_nh;
         end
      end
   end

   // ---------------- monitor ----------------
   logic [3:0] got_ev, exp_ev;
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("held", 32'(held), 32'(m_held));
         chk("ev_valid", 32'(ev_if.EvValid), 32'(m_occ != 0));
         chk("dropped", 32'(dropped), 32'(m_drop));
         if (ev_if.EvValid && rdy && !rst) begin
            got_ev = {ev_if.EvType, ev_if.EvAction};
            if (exp_q.size() == 0) begin
               chk("unexpected_event", 32'(got_ev), 32'hFFFF);
            end else begin
               exp_ev = exp_q.pop_front();
               chk("event", 32'(got_ev), 32'(exp_ev));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int cyc_n    = 0;
   int tick_per = 0;
   int rdy_mode = 1;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc_n++;
         tick = (tick_per > 0) ? (cyc_n % tick_per == 0) : ($urandom_range(0, 3) == 0);
         if (rdy_mode == 2) rdy = ($urandom_range(0, 1) == 1);
         else               rdy = (rdy_mode == 1);
      end
   endtask

   logic [15:0] pool [10];

   initial begin
      pool[0] = 16'h0000; pool[1] = 16'h0004; pool[2] = 16'h0007; pool[3] = 16'h002C;
      pool[4] = 16'h0028; pool[5] = 16'h2C07; pool[6] = 16'h0428; pool[7] = 16'h2C00;
      pool[8] = 16'h1234; pool[9] = 16'h0704;

      rst = 1'b1; rdy_mode = 1; tick_per = 0;
      cyc(2);
      chk("reset_valid", 32'(ev_if.EvValid), 32'd0);
      chk("reset_type", 32'(ev_if.EvType), 32'd0);
      chk("reset_action", 32'(ev_if.EvAction), 32'd0);
      chk("reset_held", 32'(held), 32'd0);
      rst = 1'b0;

      // single LEFT press
      kc = 16'h0004; cyc(10);
      chk("left_held", 32'(held), 32'h1);

      // bouncing word never settles
      kc = 16'h0000; cyc(10);
      for (int i = 0; i < 10; i++) begin
         kc = (i % 2 == 0) ? 16'h0004 : 16'h0000; cyc(2);
      end
      kc = 16'h0000; cyc(8);

      // two actions queued with consumer stalled, then released
      rdy_mode = 0; kc = 16'h2C07; cyc(8);
      kc = 16'h0000; cyc(8);
      rdy_mode = 1; cyc(8);

      // fire auto-repeat
      tick_per = 3; kc = 16'h002C; cyc(60);
      kc = 16'h0000; cyc(30);
      tick_per = 0;

      // full FIFO, then START press/release/press before drain
      rdy_mode = 0;
      kc = 16'h0004; cyc(8); kc = 16'h0000; cyc(8);
      kc = 16'h0007; cyc(8); kc = 16'h0000; cyc(8);
      kc = 16'h0028; cyc(8); kc = 16'h0000; cyc(8); kc = 16'h0028; cyc(8);
      chk("dropped_set", 32'(dropped), 32'd1);
      rdy_mode = 1; cyc(20);

      // reset with events queued while a key is held
      rst = 1'b1; cyc(1); rst = 1'b0;
      rdy_mode = 0; kc = 16'h0000; cyc(8);
      kc = 16'h0004; cyc(8); kc = 16'h0000; cyc(8); kc = 16'h0007; cyc(8);
      kc = 16'h0004; rst = 1'b1; cyc(1); rst = 1'b0;
      chk("midreset_valid", 32'(ev_if.EvValid), 32'd0);
      chk("midreset_dropped", 32'(dropped), 32'd0);
      rdy_mode = 1; cyc(10);

      // randomized traffic
      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         kc = pool[$urandom_range(0, 9)];
         if ($urandom_range(0, 60) == 0) begin
            rst = 1'b1; cyc(1); rst = 1'b0;
         end
         cyc($urandom_range(1, 9));
      end

      // drain
      rdy_mode = 1; tick_per = 0; kc = 16'h0000; cyc(40);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
